// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed address/data bus sequencers.
// Holds the write FSM state encodings, bus width, control vector layout and
// the Moore output decode used by rtc_write_cycle.
package rtc_bus_pkg;

    localparam int unsigned BUS_W = 8;

    typedef enum logic [2:0] {
        W0    = 3'b000,
        W1    = 3'b001,
        W2    = 3'b010,
        W3    = 3'b011,
        W4    = 3'b100,
        W5    = 3'b101,
        W6    = 3'b110,
        W_BAD = 3'b111
    } wr_state_e;

    // Pad control vector, ordered {AD, CS, RD, WR, TS, ad_mux}
    typedef struct packed {
        logic ad;
        logic cs;
        logic rd;
        logic wr;
        logic ts;
        logic ad_mux;
    } bus_ctl_t;

    localparam bus_ctl_t IDLE_CTL = 6'b111100;

    // Moore decode of the pad controls from the state register
    function automatic bus_ctl_t decode_ctl(input wr_state_e s);
        bus_ctl_t c;
        case (s)
            W1, W3:  c = 6'b011110;
            W2:      c = 6'b001010;
            W4, W6:  c = 6'b111111;
            W5:      c = 6'b101011;
            default: c = IDLE_CTL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rtc_write_timer.sv
// Phase timer for the RTC write sequencer.
// Down-counter: load presets the count, otherwise it decrements toward zero
// and holds there. done is high while the count reads zero.
// Ports: clk, rst (async active-low), load, load_val[CNT_W-1:0], done.
module rtc_write_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, else decrement until zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/rtc_write_cycle.sv
// Write-cycle sequencer for the RTC multiplexed address/data bus.
// On an accepted start it runs address setup/strobe/hold, data setup/strobe
// and a one-cycle done state, driving timed active-low CS/WR strobes.
// Ports:
//   clk, rst (async active-low)
//   in              start request, sampled only in W0
//   addr_in/data_in captured when the start is accepted
//   bus_out         pad data, ad_mux ? data_q : addr_q
//   AD, CS, RD, WR  bus controls (CS/WR/RD active low, RD tied high)
//   TS              tri-state driver enable
//   ad_mux          bus_out source select
//   write_end       one-cycle completion pulse
//   state           current FSM state (debug)
//   overrun         only with WR_OVERRUN_EN: start seen while busy (registered)
// Optional feature macro: WR_OVERRUN_EN.
module rtc_write_cycle
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 4,
    parameter int unsigned T_TURN   = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic [BUS_W-1:0] addr_in,
    input  logic [BUS_W-1:0] data_in,
    output logic [BUS_W-1:0] bus_out,
    output logic             AD,
    output logic             CS,
    output logic             RD,
    output logic             WR,
    output logic             TS,
    output logic             ad_mux,
    output logic             write_end,
`ifdef WR_OVERRUN_EN
    output logic             overrun,
`endif
    output logic [2:0]       state
);

    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] LD_TURN   = CNT_W'(T_TURN - 1);

    wr_state_e        state_q;
    wr_state_e        state_d;
    logic [BUS_W-1:0] addr_q;
    logic [BUS_W-1:0] addr_d;
    logic [BUS_W-1:0] data_q;
    logic [BUS_W-1:0] data_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    bus_ctl_t         ctl;

    rtc_write_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    // Next-state, timer load and capture; each timed state lasts N cycles
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            W0: begin
                if (in) begin
                    addr_d   = addr_in;
                    data_d   = data_in;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                    state_d  = W1;
                end
            end
            W1: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_STROBE;
                    state_d  = W2;
                end
            end
            W2: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_TURN;
                    state_d  = W3;
                end
            end
            W3: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                    state_d  = W4;
                end
            end
            W4: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_STROBE;
                    state_d  = W5;
                end
            end
            W5: begin
                if (tmr_done) begin
                    state_d = W6;
                end
            end
            W6:      state_d = W0;
            default: state_d = W0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= W0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode from the state register only
    assign ctl                            = decode_ctl(state_q);
    assign {AD, CS, RD, WR, TS, ad_mux}   = ctl;
    assign write_end                      = (state_q == W6);
    assign state                          = state_q;
    assign bus_out                        = ctl.ad_mux ? data_q : addr_q;

`ifdef WR_OVERRUN_EN
    logic overrun_q;

    // Flag a start request that arrives while a write is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= in && (state_q inside {W1, W2, W3, W4, W5, W6});
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_rtc_write_cycle.sv
module tb_rtc_write_cycle;
    import rtc_bus_pkg::*;

    localparam int unsigned T_STROBE = 4;
    localparam int unsigned LAT      = 2*2 + 2*4 + 3;
    localparam int unsigned PERIOD   = LAT + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_i;
    logic [7:0] addr_i, data_i;
    logic [7:0] bus_out;
    logic       AD, CS, RD, WR, TS, ad_mux, write_end;
    logic [2:0] state;
    logic       overrun;

    logic       in_f;
    logic [7:0] addr_f, data_f, bus_f;
    logic       AD_f, CS_f, RD_f, WR_f, TS_f, mux_f, wend_f;
    logic [2:0] state_f;
    logic       ovr_f;

    always #5 clk = ~clk;

    rtc_write_cycle u_dut (
        .clk(clk), .rst(rst), .in(in_i), .addr_in(addr_i), .data_in(data_i),
        .bus_out(bus_out), .AD(AD), .CS(CS), .RD(RD), .WR(WR), .TS(TS),
        .ad_mux(ad_mux), .write_end(write_end),
`ifdef WR_OVERRUN_EN
        .overrun(overrun),
`endif
        .state(state)
    );

    rtc_write_cycle #(.T_SETUP(1), .T_STROBE(1), .T_TURN(1), .CNT_W(4)) u_fast (
        .clk(clk), .rst(rst), .in(in_f), .addr_in(addr_f), .data_in(data_f),
        .bus_out(bus_f), .AD(AD_f), .CS(CS_f), .RD(RD_f), .WR(WR_f), .TS(TS_f),
        .ad_mux(mux_f), .write_end(wend_f),
`ifdef WR_OVERRUN_EN
        .overrun(ovr_f),
`endif
        .state(state_f)
    );

`ifndef WR_OVERRUN_EN
    assign overrun = 1'b0;
    assign ovr_f   = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: one record per accepted start
    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         acc;
    } sb_t;
    sb_t sb[$];

    int   cyc = 0;
    int   next_ok = 0;
    logic exp_ovr = 1'b0;
    int   ovr_cnt = 0;
    int   wend_cnt = 0;
    int   last_wend_cyc = 0;
    int   last_lat = 0;
    logic [7:0] last_a = '0, last_d = '0;
    int   a_len = 0, d_len = 0;
    logic prev_cs = 1'b1, prev_ad = 1'b1;

    // Acceptance model: idle unless a write is still within its period
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        exp_ovr = 1'b0;
        if (!rst) begin
            next_ok = cyc + 1;
        end else if (in_i) begin
            if (cyc >= next_ok) begin
                sb.push_back('{addr_i, data_i, cyc});
                next_ok = cyc + PERIOD;
            end else begin
                exp_ovr = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge rst);
        sb.delete();
        a_len = 0;
        d_len = 0;
        exp_ovr = 1'b0;
    end

    // Output monitor for the default-timing instance
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rd_high", RD, 1);
            if (!CS) chk("cs_needs_ts", TS, 1);
            if (!CS && !prev_cs) chk("ad_stable", AD, prev_ad);
            if (!CS) begin
                if (sb.size() == 0) chk("strobe_txn_pending", sb.size(), 1);
                else if (!AD) begin a_len++; last_a = bus_out; chk("addr_bus", bus_out, sb[0].addr); end
                else begin d_len++; last_d = bus_out; chk("data_bus", bus_out, sb[0].data); end
            end
            if (write_end) begin
                if (sb.size() == 0) chk("write_end_pending", sb.size(), 1);
                else begin
                    last_lat = cyc - sb[0].acc;
                    chk("latency", last_lat, LAT);
                    chk("addr_strobe_len", a_len, T_STROBE);
                    chk("data_strobe_len", d_len, T_STROBE);
                    void'(sb.pop_front());
                end
                wend_cnt++;
                last_wend_cyc = cyc;
                a_len = 0;
                d_len = 0;
            end
`ifdef WR_OVERRUN_EN
            chk("overrun", overrun, exp_ovr);
            if (overrun) ovr_cnt++;
`endif
            prev_cs = CS;
            prev_ad = AD;
        end else begin
            prev_cs = 1'b1;
        end
    end

    task automatic start_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); #1;
        addr_i = a; data_i = d; in_i = 1'b1;
        @(negedge clk); #1;
        in_i = 1'b0;
    endtask

    task automatic wait_wend(input int target, input int budget);
        int n = 0;
        while (wend_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("write_end_timeout", 32'(wend_cnt >= target), 1);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[4];
    logic [2:0] fast_st[7];
    logic [5:0] fast_ctl[7];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c0, c1, c2;
        rst = 1'b0; in_i = 1'b0; addr_i = '0; data_i = '0;
        in_f = 1'b0; addr_f = '0; data_f = '0;

        vecs[0] = '{8'h0A, 8'h5C, LAT};
        vecs[1] = '{8'hFF, 8'h00, LAT};
        vecs[2] = '{8'h00, 8'hFF, LAT};
        vecs[3] = '{8'h81, 8'h7E, LAT};
        fast_st  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        fast_ctl = '{6'b011110, 6'b001010, 6'b011110, 6'b111111,
                     6'b101011, 6'b111111, 6'b111100};

        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_ctl", {AD, CS, RD, WR, TS, ad_mux}, 6'b111100);
        chk("rst_bus", bus_out, 0);
        chk("rst_wend", write_end, 0);
        chk("rst_ovr", overrun, 0);
        #1 rst = 1'b1;

        // Table-driven single writes
        for (int i = 0; i < 4; i++) begin
            base = wend_cnt;
            start_write(vecs[i].addr, vecs[i].data);
            wait_wend(base + 1, 40);
            chk("vec_lat", last_lat, vecs[i].exp_lat);
            chk("vec_addr", last_a, vecs[i].addr);
            chk("vec_data", last_d, vecs[i].data);
        end

        // Inputs change during address hold: captured values must persist
        base = wend_cnt;
        start_write(8'h3C, 8'hA5);
        repeat (7) @(negedge clk);
        #1;
        chk("midcycle_state", state, 3);
        addr_i = 8'hFF; data_i = 8'h00;
        wait_wend(base + 1, 40);
        chk("midcycle_addr", last_a, 8'h3C);
        chk("midcycle_data", last_d, 8'hA5);

        // Start held high: back-to-back writes one W0 cycle apart
        base = wend_cnt;
        addr_i = 8'h12; data_i = 8'h34; in_i = 1'b1;
        wait_wend(base + 1, 40); c0 = last_wend_cyc;
        wait_wend(base + 2, 40); c1 = last_wend_cyc;
        wait_wend(base + 3, 40); c2 = last_wend_cyc;
        in_i = 1'b0;
        chk("b2b_period_1", c1 - c0, PERIOD);
        chk("b2b_period_2", c2 - c1, PERIOD);

        // Reset in the middle of the address strobe
        repeat (3) @(negedge clk);
        base = wend_cnt;
        start_write(8'h11, 8'h22);
        for (int n = 0; n < 10 && CS; n++) begin @(negedge clk); #1; end
        chk("pre_rst_cs", CS, 0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_cs_wr", {CS, WR}, 2'b11);
        chk("mid_rst_ts", TS, 0);
        chk("mid_rst_ad_rd_mux", {AD, RD, ad_mux}, 3'b110);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_bus", bus_out, 0);
        chk("mid_rst_wend", write_end, 0);
        @(negedge clk); #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("no_wend_after_rst", wend_cnt, base);

        // Minimum timing instance: each state one cycle
        @(negedge clk); #1;
        in_f = 1'b1; addr_f = 8'h77; data_f = 8'h88;
        @(negedge clk); #1;
        in_f = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("fast_state", state_f, fast_st[i]);
            chk("fast_ctl", {AD_f, CS_f, RD_f, WR_f, TS_f, mux_f}, fast_ctl[i]);
            chk("fast_wend", wend_f, 32'(i == 5));
            chk("fast_ovr", ovr_f, 0);
            if (i == 1) chk("fast_addr", bus_f, 8'h77);
            if (i == 4) chk("fast_data", bus_f, 8'h88);
            @(negedge clk); #1;
        end

`ifdef WR_OVERRUN_EN
        // Start pulse during data setup: overrun only, no extra write
        base = wend_cnt;
        ovr_cnt = 0;
        start_write(8'h5A, 8'hC3);
        repeat (9) @(negedge clk);
        #1;
        chk("ovr_in_w4", state, 4);
        in_i = 1'b1;
        @(negedge clk); #1;
        in_i = 1'b0;
        wait_wend(base + 1, 40);
        chk("ovr_data", last_d, 8'hC3);
        repeat (25) @(negedge clk);
        #1;
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_no_second", wend_cnt, base + 1);
`endif

        // Recovery after reset
        base = wend_cnt;
        start_write(8'hC0, 8'hDE);
        wait_wend(base + 1, 40);
        chk("final_addr", last_a, 8'hC0);
        chk("final_data", last_d, 8'hDE);
        chk("final_queue_empty", sb.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
